spike_replay_sequencer: RTL and testbench
=========================================

Name: spike_replay_sequencer

Overview:
- Synthesizable successor to the bench-side spike-file driver. Stores up to DEPTH pre-synaptic spike vectors, then replays a programmable number of time steps into one SNN layer over the pre_synp_avail/layer_avail handshake.
- Accumulates per-neuron post-synaptic spike counts.
- Adds two things the bench driver lacks: wrap-around replay (time steps may exceed the stored vectors) and on-chip result collection.
- Sits between the host/loader and top_wrapper.

Parameters:
- PRE_SYN_LAYER_SIZE, 32, width of one input spike vector.
- LAYER_SIZE, 16, number of post-synaptic neurons.
- DEPTH, 16, spike-vector buffer entries.
- STEP_W, 8, width of num_steps and step_idx.
- CNT_W, 8, width of each per-neuron spike counter (saturating).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear_buf  in  1  IDLE only: empties buffer (stored count := 0).
- load_valid  in  1  load_data valid.
- load_data  in  PRE_SYN_LAYER_SIZE  spike vector to store.
- load_ready  out  1  buffer accepts a write this cycle.
- start  in  1  1-cycle request to begin a run.
- num_steps  in  STEP_W  time steps to run; sampled on accepted start.
- layer_avail  in  1  layer idle/ready; falls when it accepts a step, rises when the step completes.
- post_syn_spk  in  LAYER_SIZE  layer output spikes; valid on the cycle layer_avail re-rises.
- pre_synp_avail  out  1  1-cycle step-issue pulse.
- pre_synpt_spk_train  out  PRE_SYN_LAYER_SIZE  vector being issued; held stable until the next issue.
- busy  out  1  high outside IDLE.
- done  out  1  1-cycle pulse at end of run.
- step_idx  out  STEP_W  steps completed in the current run.
- spike_count  out  LAYER_SIZE*CNT_W  flattened counters; neuron i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
Reset (rst=0, asynchronous):
- State IDLE; write pointer, stored count and read pointer := 0.
- All outputs := 0, except load_ready, which follows its equation (1 after reset).
- Applies at any time. A mid-run reset aborts the run with no done pulse, and buffer contents are considered lost.

Loading:
- load_ready = (state==IDLE) && (stored<DEPTH) && !start && !clear_buf.
- Write when load_valid && load_ready: entry[stored] := load_data, stored++.
- Full (stored==DEPTH): further writes ignored.
- clear_buf has priority over load.
- start has priority over load (load_ready is low when start is high).

States:
- IDLE: on start, clear spike_count and step_idx, latch num_steps, set rd_ptr := 0.
  - If latched num_steps==0 or stored==0: go to FINISH.
  - Otherwise go to ISSUE.
  - start outside IDLE is ignored.
- ISSUE: wait for layer_avail==1. In that cycle:
  - pre_synpt_spk_train := entry[rd_ptr] and pre_synp_avail := 1, both registered and visible the next cycle.
  - Advance rd_ptr, wrapping to 0 when rd_ptr==stored-1.
  - Go to WAIT_ACK.
- WAIT_ACK: wait for layer_avail==0, then go to WAIT_RES. pre_synp_avail is high only during the first WAIT_ACK cycle.
- WAIT_RES: wait for layer_avail==1. In that cycle:
  - For each i: spike_count[i] += post_syn_spk[i], saturating at 2^CNT_W-1.
  - step_idx++.
  - If step_idx+1 == num_steps, go to FINISH; otherwise go to ISSUE, whose next issue can be 1 cycle later.
- FINISH: done := 1 for one cycle, then IDLE. Counts and step_idx hold until the next accepted start.

Rules:
- Replay order is entry 0..stored-1, repeated cyclically.
- Minimum step period is 4 cycles plus layer latency.
- layer_avail already low in ISSUE: no issue, wait.
- Buffer writes never occur while busy.

Test Plan:
- Load 6 vectors {32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20}; start with num_steps=6; layer model latency 3 asserts post_syn_spk=16'h0003 every step.
  - Expect 6 pre_synp_avail pulses carrying the vectors in order.
  - Expect done once; step_idx=6; counts[0]=counts[1]=6, others 0.
- Load 3 vectors A,B,C; num_steps=7.
  - Expect issued order A,B,C,A,B,C,A; step_idx=7.
- Hold load_valid for 20 cycles in IDLE (DEPTH=16).
  - Expect exactly 16 writes; load_ready=0 afterwards; clear_buf restores load_ready=1.
- num_steps=0, and separately start with an empty buffer.
  - Expect done 2 cycles after start, no pre_synp_avail pulse, counts=0.
- CNT_W=4; 20 steps with post_syn_spk bit 0 always set.
  - Expect counts[0]=15, saturated, with no wrap.
- Drop rst to 0 in WAIT_RES of step 3.
  - Expect immediate IDLE with all outputs 0 and no done.
  - After releasing rst: load_ready=1 and stored=0.

Source files
------------

// File: rtl/spike_replay_sequencer.sv
// Spike replay sequencer: buffers pre-synaptic spike vectors, replays them
// cyclically into one SNN layer over the pre_synp_avail/layer_avail
// handshake, and accumulates saturating per-neuron post-synaptic spike counts.
module spike_replay_sequencer #(
  parameter int PRE_SYN_LAYER_SIZE = 32,
  parameter int LAYER_SIZE         = 16,
  parameter int DEPTH              = 16,
  parameter int STEP_W             = 8,
  parameter int CNT_W              = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear_buf,
  input  logic                            load_valid,
  input  logic [PRE_SYN_LAYER_SIZE-1:0]   load_data,
  output logic                            load_ready,
  input  logic                            start,
  input  logic [STEP_W-1:0]               num_steps,
  input  logic                            layer_avail,
  input  logic [LAYER_SIZE-1:0]           post_syn_spk,
  output logic                            pre_synp_avail,
  output logic [PRE_SYN_LAYER_SIZE-1:0]   pre_synpt_spk_train,
  output logic                            busy,
  output logic                            done,
  output logic [STEP_W-1:0]               step_idx,
  output logic [LAYER_SIZE*CNT_W-1:0]     spike_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW    = $clog2(DEPTH + 1);
  localparam logic [SW-1:0] DEPTH_C = SW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_RES,
    S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic [PRE_SYN_LAYER_SIZE-1:0]      buf_mem [DEPTH];
  logic [SW-1:0]                      stored;
  logic [PTR_W-1:0]                   rd_ptr;
  logic [STEP_W-1:0]                  steps_lat;
  logic [LAYER_SIZE-1:0][CNT_W-1:0]   cnt;

  logic start_acc;
  logic wr_en;
  logic issue_fire;
  logic step_done;
  logic last_step;
  logic rd_last;

  assign start_acc  = (state == S_IDLE) && start;
  assign load_ready = (state == S_IDLE) && (stored != DEPTH_C) && !start && !clear_buf;
  assign wr_en      = load_valid && load_ready;
  assign issue_fire = (state == S_ISSUE) && layer_avail;
  assign step_done  = (state == S_WAIT_RES) && layer_avail;
  assign last_step  = (step_idx + STEP_W'(1)) == steps_lat;
  assign rd_last    = (SW'(rd_ptr) == (stored - SW'(1)));
  assign busy        = (state != S_IDLE);
  assign spike_count = cnt;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic for the replay handshake.
  // NOTE: the default assignment first guarantees state_nxt is written on
  // every path, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = ((num_steps == '0) || (stored == '0)) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE:    if (layer_avail)  state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (!layer_avail) state_nxt = S_WAIT_RES;
      S_WAIT_RES: if (layer_avail)  state_nxt = last_step ? S_FINISH : S_ISSUE;
      S_FINISH:   state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Stored-entry count; doubles as the write pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stored <= '0;
    end else if ((state == S_IDLE) && clear_buf) begin
      stored <= '0;
    end else if (wr_en) begin
      stored <= stored + SW'(1);
    end
  end

  // Spike-vector storage.
  // NOTE: the buffer array has no reset; contents are only meaningful below
  // 'stored', which is reset, so resetting the array would just cost flops.
  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[PTR_W'(stored)] <= load_data;
  end

  // Run control: issue register, read pointer, step counter, done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr              <= '0;
      steps_lat           <= '0;
      step_idx            <= '0;
      pre_synp_avail      <= 1'b0;
      pre_synpt_spk_train <= '0;
      done                <= 1'b0;
    end else begin
      pre_synp_avail <= issue_fire;
      done           <= (state == S_FINISH);
      if (start_acc) begin
        rd_ptr    <= '0;
        steps_lat <= num_steps;
        step_idx  <= '0;
      end
      if (issue_fire) begin
        pre_synpt_spk_train <= buf_mem[rd_ptr];
        rd_ptr              <= rd_last ? '0 : rd_ptr + PTR_W'(1);
      end
      if (step_done) step_idx <= step_idx + STEP_W'(1);
    end
  end

  // Per-neuron saturating spike counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (start_acc) begin
      cnt <= '0;
    end else if (step_done) begin
      for (int i = 0; i < LAYER_SIZE; i++) begin
        if (post_syn_spk[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spike_replay_sequencer.sv
// Directed bench for spike_replay_sequencer. Two instances share stimulus:
// the default one (CNT_W=8) and a CNT_W=4 one that runs in lockstep and
// exposes counter saturation. A behavioural layer model drives the handshake.
module tb_spike_replay_sequencer;

  localparam int PRE = 32;
  localparam int LS  = 16;
  localparam int SW  = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            clear_buf;
  logic            load_valid;
  logic [PRE-1:0]  load_data;
  logic            load_ready, load_ready_c4;
  logic            start;
  logic [SW-1:0]   num_steps;
  logic            layer_avail;
  logic [LS-1:0]   post_syn_spk;
  logic            pre_synp_avail, pre_synp_avail_c4;
  logic [PRE-1:0]  train, train_c4;
  logic            busy, busy_c4;
  logic            done, done_c4;
  logic [SW-1:0]   step_idx, step_idx_c4;
  logic [LS*8-1:0] cnt8;
  logic [LS*4-1:0] cnt4;

  spike_replay_sequencer dut (
    .clk(clk), .rst(rst), .clear_buf(clear_buf), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .start(start),
    .num_steps(num_steps), .layer_avail(layer_avail), .post_syn_spk(post_syn_spk),
    .pre_synp_avail(pre_synp_avail), .pre_synpt_spk_train(train), .busy(busy),
    .done(done), .step_idx(step_idx), .spike_count(cnt8)
  );

  spike_replay_sequencer #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .clear_buf(clear_buf), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready_c4), .start(start),
    .num_steps(num_steps), .layer_avail(layer_avail), .post_syn_spk(post_syn_spk),
    .pre_synp_avail(pre_synp_avail_c4), .pre_synpt_spk_train(train_c4), .busy(busy_c4),
    .done(done_c4), .step_idx(step_idx_c4), .spike_count(cnt4)
  );

  always #5 clk = ~clk;

  int             checks = 0;
  int             errors = 0;
  int             done_cnt = 0;
  logic [LS-1:0]  pattern = '0;
  logic [PRE-1:0] issued [$];
  logic [PRE-1:0] exp_q [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stimulus and checks happen 1 time unit after the falling edge, after the
  // layer model has reacted to that edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Layer model: latency 3, returns 'pattern' when it becomes available again.
  initial begin : layer_model
    int lcnt;
    lcnt = 0;
    layer_avail  = 1'b1;
    post_syn_spk = '0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (!rst) begin
        layer_avail  = 1'b1;
        post_syn_spk = '0;
        lcnt         = 0;
      end else if (lcnt != 0) begin
        lcnt--;
        if (lcnt == 0) begin
          layer_avail  = 1'b1;
          post_syn_spk = pattern;
        end
      end else if (pre_synp_avail) begin
        issued.push_back(train);
        layer_avail  = 1'b0;
        post_syn_spk = '0;
        lcnt         = 3;
      end
    end
  end

  task automatic load_vec(input logic [PRE-1:0] v);
    load_valid = 1'b1;
    load_data  = v;
    step();
    load_valid = 1'b0;
  endtask

  task automatic clear();
    clear_buf = 1'b1;
    step();
    clear_buf = 1'b0;
  endtask

  task automatic run(input string tag, input logic [SW-1:0] n);
    int  prev;
    bit  got;
    prev = done_cnt;
    got  = 1'b0;
    issued.delete();
    start     = 1'b1;
    num_steps = n;
    step();
    start = 1'b0;
    for (int c = 0; c < 500 && !got; c++) begin
      step();
      if (done_cnt > prev) got = 1'b1;
    end
    check({tag, "_done_seen"}, got, 1'b1);
    step();
    check({tag, "_done_once"}, done_cnt - prev, 1);
  endtask

  task automatic compare_issued(input string tag);
    check({tag, "_issue_count"}, issued.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < issued.size()) check($sformatf("%s_issue[%0d]", tag, i), issued[i], exp_q[i]);
    end
  endtask

  initial begin : stimulus
    logic [PRE-1:0] abc [3];
    int wr;
    int prev;
    bit seen3;

    rst = 1'b0; clear_buf = 1'b0; load_valid = 1'b0; load_data = '0;
    start = 1'b0; num_steps = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_avail", pre_synp_avail, 0);
    check("rst_train", train, 0);
    check("rst_step_idx", step_idx, 0);
    check("rst_counts", cnt8, 0);
    check("rst_load_ready", load_ready, 1);
    step(); step();
    rst = 1'b1;
    step();

    // Six one-hot vectors, 6 steps, layer returns 16'h0003.
    pattern = 16'h0003;
    exp_q = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20};
    foreach (exp_q[i]) load_vec(exp_q[i]);
    run("t1", 8'd6);
    compare_issued("t1");
    check("t1_step_idx", step_idx, 6);
    check("t1_counts8", cnt8, 128'h0606);
    check("t1_counts4", cnt4, 64'h66);
    check("t1_train_hold", train, 32'h20);
    check("t1_idle", busy, 0);

    // Three vectors replayed cyclically over 7 steps.
    clear();
    pattern = 16'h8001;
    abc[0] = 32'hA5A5_0001; abc[1] = 32'h5A5A_0002; abc[2] = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) load_vec(abc[k]);
    exp_q.delete();
    for (int k = 0; k < 7; k++) exp_q.push_back(abc[k % 3]);
    run("t2", 8'd7);
    compare_issued("t2");
    check("t2_step_idx", step_idx, 7);
    check("t2_counts8", cnt8, 128'h0700_0000_0000_0000_0000_0000_0000_0007);
    check("t2_counts4", cnt4, 64'h7000_0000_0000_0007);

    // num_steps == 0 with a non-empty buffer: done two cycles after start.
    issued.delete();
    prev = done_cnt;
    start = 1'b1; num_steps = 8'd0;
    step();
    start = 1'b0;
    check("t4a_busy_finish", busy, 1);
    check("t4a_done_early", done, 0);
    step();
    check("t4a_done", done, 1);
    check("t4a_idle", busy, 0);
    step();
    check("t4a_done_once", done_cnt - prev, 1);
    check("t4a_no_issue", issued.size(), 0);
    check("t4a_counts", cnt8, 0);
    check("t4a_step_idx", step_idx, 0);

    // Empty buffer with nonzero num_steps.
    clear();
    issued.delete();
    prev = done_cnt;
    start = 1'b1; num_steps = 8'd5;
    step();
    start = 1'b0;
    check("t4b_done_early", done, 0);
    step();
    check("t4b_done", done, 1);
    step();
    check("t4b_done_once", done_cnt - prev, 1);
    check("t4b_no_issue", issued.size(), 0);

    // Hold load_valid for 20 cycles: exactly DEPTH writes, then full.
    wr = 0;
    for (int i = 0; i < 20; i++) begin
      load_valid = 1'b1;
      load_data  = 32'h100 + i;
      if (load_ready) wr++;
      step();
    end
    load_valid = 1'b0;
    check("t3_writes", wr, 16);
    check("t3_full_ready", load_ready, 0);
    // 20 steps over a full buffer; bit 0 always set saturates the 4-bit counter.
    pattern = 16'h0001;
    exp_q.delete();
    for (int k = 0; k < 20; k++) exp_q.push_back(32'h100 + (k % 16));
    run("t3", 8'd20);
    compare_issued("t3");
    check("t3_step_idx", step_idx, 20);
    check("t3_counts8", cnt8, 128'h14);
    check("t3_counts4_sat", cnt4, 64'hF);
    clear_buf = 1'b1;
    #1;
    check("t3_clear_blocks", load_ready, 0);
    step();
    clear_buf = 1'b0;
    #1;
    check("t3_clear_ready", load_ready, 1);

    // Reset asserted in WAIT_RES of step 3.
    pattern = 16'h00F0;
    for (int k = 0; k < 4; k++) load_vec(32'hF000 + k);
    issued.delete();
    prev = done_cnt;
    start = 1'b1; num_steps = 8'd10;
    step();
    start = 1'b0;
    seen3 = 1'b0;
    for (int c = 0; c < 200 && !seen3; c++) begin
      step();
      if (issued.size() >= 3) seen3 = 1'b1;
    end
    check("t5_third_issue", seen3, 1);
    step();
    check("t5_pre_busy", busy, 1);
    check("t5_pre_step_idx", step_idx, 2);
    rst = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_avail", pre_synp_avail, 0);
    check("t5_train", train, 0);
    check("t5_step_idx", step_idx, 0);
    check("t5_counts", cnt8, 0);
    check("t5_done", done, 0);
    check("t5_load_ready", load_ready, 1);
    step(); step(); step();
    rst = 1'b1;
    step(); step(); step();
    check("t5_no_done", done_cnt - prev, 0);
    check("t5_idle_after", busy, 0);
    check("t5_ready_after", load_ready, 1);
    // Stored count was cleared: a single new vector must be the only one replayed.
    pattern = 16'h0000;
    load_vec(32'hCAFE_0001);
    exp_q = '{32'hCAFE_0001, 32'hCAFE_0001, 32'hCAFE_0001};
    run("t5b", 8'd3);
    compare_issued("t5b");
    check("t5b_step_idx", step_idx, 3);
    check("t5b_counts", cnt8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
